// File: rtl/sysid_read_master_pkg.sv
// Shared types and constants for the boot-time system ID read master.
// The counter width helper keeps the timeout counter just wide enough for its limit.
package sysid_read_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    FINISH
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Width needed to count from 0 up to cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/sysid_read_timer.sv
// Per-transaction cycle counter: cleared by load, counts while enabled and
// saturates at limit, where expired stays high until the next load.
module sysid_read_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/sysid_read_master.sv
// Avalon-MM read master that reads the system ID and build timestamp words at
// boot and reports whether they match the values this image was built for.
module sysid_read_master
  import sysid_read_master_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1328062037,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int          TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata
);

  localparam int              CNT_W     = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t next_state;
  logic   accepted;
  logic   expired;
  logic   load_timer;
  logic   next_read;
  logic   next_address;

  assign accepted = avm_read & ~avm_waitrequest;

  sysid_read_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (load_timer),
    .enable (busy),
    .limit  (CNT_LIMIT),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Events are checked before expiry so a response on the last allowed cycle still counts.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = REQ_ID;
      REQ_ID: begin
        if (accepted)     next_state = WAIT_ID;
        else if (expired) next_state = FINISH;
      end
      WAIT_ID: begin
        if (avm_readdatavalid) next_state = CHECK_TIMESTAMP ? REQ_TS : FINISH;
        else if (expired)      next_state = FINISH;
      end
      REQ_TS: begin
        if (accepted)     next_state = WAIT_TS;
        else if (expired) next_state = FINISH;
      end
      WAIT_TS: begin
        if (avm_readdatavalid || expired) next_state = FINISH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == REQ_ID) || (state == WAIT_ID) ||
                   (state == REQ_TS) || (state == WAIT_TS);
    done         = (state == FINISH);
    next_read    = (next_state == REQ_ID) || (next_state == REQ_TS);
    next_address = ((next_state == REQ_TS) || (next_state == WAIT_TS)) ? ADDR_TS : ADDR_ID;
    load_timer   = ((next_state == REQ_ID) && (state != REQ_ID)) ||
                   ((next_state == REQ_TS) && (state != REQ_TS));
  end

  // Bus outputs are registered from next_state so they hold steady through waitrequest.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
    end else begin
      avm_read    <= next_read;
      avm_address <= next_address;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
          end
        end
        REQ_ID, REQ_TS: begin
          if (!accepted && expired) timeout <= 1'b1;
        end
        WAIT_ID: begin
          if (avm_readdatavalid) begin
            id_value <= avm_readdata;
            id_ok    <= (avm_readdata == EXPECTED_ID);
            if (!CHECK_TIMESTAMP) ts_ok <= 1'b1;
          end else if (expired) begin
            timeout <= 1'b1;
          end
        end
        WAIT_TS: begin
          if (avm_readdatavalid) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
          end else if (expired) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_read_master.sv
// Directed bench for sysid_read_master: a small Avalon slave model answers reads,
// and each task drives one scenario and checks hand-computed expectations.
module tb_sysid_read_master;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1328062037;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0;

  // Slave model controls and observations
  int          stall_cycles = 0;
  logic [31:0] data_id = EXP_ID;
  logic [31:0] data_ts = EXP_TS;
  bit          drop_id = 1'b0;
  bit          drop_ts = 1'b0;
  bit          inject_rdv = 1'b0;
  logic [31:0] inject_data = '0;
  int          acc_id = 0;
  int          acc_ts = 0;
  bit          stall_broken = 1'b0;

  int          n_compared = 0;
  int          n_mismatched = 0;

  sysid_read_master #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .CHECK_TIMESTAMP   (1'b1),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata)
  );

  always #5 clock = ~clock;

  // Slave: decides at each falling edge what the next rising edge will see; latency 1.
  initial begin : slave_model
    int          stall_cnt;
    bit          stalling;
    bit          pend;
    logic [31:0] pend_data;
    logic        stall_addr;
    stall_cnt = 0; stalling = 1'b0; pend = 1'b0; pend_data = '0; stall_addr = 1'b0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      if (reset) begin
        pend = 1'b0; stall_cnt = 0; stalling = 1'b0; avm_waitrequest = 1'b0;
      end else begin
        if (pend) begin
          avm_readdatavalid = 1'b1; avm_readdata = pend_data; pend = 1'b0;
        end else if (inject_rdv) begin
          avm_readdatavalid = 1'b1; avm_readdata = inject_data; inject_rdv = 1'b0;
        end
        if (stalling && (avm_read !== 1'b1 || avm_address !== stall_addr)) stall_broken = 1'b1;
        if (avm_read === 1'b1) begin
          if (stall_cnt < stall_cycles) begin
            if (!stalling) stall_addr = avm_address;
            avm_waitrequest = 1'b1; stalling = 1'b1; stall_cnt++;
          end else begin
            avm_waitrequest = 1'b0; stalling = 1'b0; stall_cnt = 0;
            if (avm_address == 1'b0) begin
              acc_id++;
              if (!drop_id) begin pend = 1'b1; pend_data = data_id; end
            end else begin
              acc_ts++;
              if (!drop_ts) begin pend = 1'b1; pend_data = data_ts; end
            end
          end
        end else begin
          avm_waitrequest = 1'b0; stalling = 1'b0; stall_cnt = 0;
        end
      end
    end
  end

  task automatic reset_counts;
    acc_id = 0; acc_ts = 0; stall_broken = 1'b0;
  endtask

  // Returns at the falling edge of cycle 1, where cycle 0 is the one with start high.
  task automatic pulse_start;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int cyc);
    cyc = -1;
    for (int n = first; n < first + 40; n++) begin
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_compared++; if ({busy, done, avm_read, avm_address, id_ok, ts_ok, timeout} !== 7'b0) begin n_mismatched++; $display("[TB] FAIL reset_ctrl_flags: got %b, expected 0000000", {busy, done, avm_read, avm_address, id_ok, ts_ok, timeout}); end
    n_compared++; if (id_value !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_id_value: got %0h, expected 0", id_value); end
    n_compared++; if (ts_value !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_ts_value: got %0h, expected 0", ts_value); end
    reset = 1'b0;
    @(negedge clock);
    n_compared++; if ({busy, avm_read} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL idle_after_reset: got %b, expected 00", {busy, avm_read}); end
  endtask

  task automatic test_nominal;
    int cyc;
    reset_counts(); data_id = EXP_ID; data_ts = EXP_TS;
    pulse_start();
    n_compared++; if ({busy, avm_read, avm_address} !== 3'b110) begin n_mismatched++; $display("[TB] FAIL nominal_req_id_c1: got %b, expected 110", {busy, avm_read, avm_address}); end
    wait_done(1, cyc);
    n_compared++; if (cyc !== 5) begin n_mismatched++; $display("[TB] FAIL nominal_done_cycle: got %0d, expected 5", cyc); end
    n_compared++; if ({busy, id_ok, ts_ok, timeout} !== 4'b0110) begin n_mismatched++; $display("[TB] FAIL nominal_flags: got %b, expected 0110", {busy, id_ok, ts_ok, timeout}); end
    n_compared++; if (id_value !== EXP_ID) begin n_mismatched++; $display("[TB] FAIL nominal_id_value: got %0h, expected %0h", id_value, EXP_ID); end
    n_compared++; if (ts_value !== EXP_TS) begin n_mismatched++; $display("[TB] FAIL nominal_ts_value: got %0h, expected %0h", ts_value, EXP_TS); end
    n_compared++; if (acc_id !== 1 || acc_ts !== 1) begin n_mismatched++; $display("[TB] FAIL nominal_accepts: got %0d/%0d, expected 1/1", acc_id, acc_ts); end
    @(negedge clock);
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nominal_done_pulse: got %b, expected 0", done); end
  endtask

  task automatic test_id_mismatch;
    int cyc;
    reset_counts(); data_id = 32'h12345678; data_ts = EXP_TS;
    pulse_start();
    wait_done(1, cyc);
    n_compared++; if (cyc !== 5) begin n_mismatched++; $display("[TB] FAIL mismatch_done_cycle: got %0d, expected 5", cyc); end
    n_compared++; if ({id_ok, ts_ok, timeout} !== 3'b010) begin n_mismatched++; $display("[TB] FAIL mismatch_flags: got %b, expected 010", {id_ok, ts_ok, timeout}); end
    n_compared++; if (id_value !== 32'h12345678) begin n_mismatched++; $display("[TB] FAIL mismatch_id_value: got %0h, expected 12345678", id_value); end
    n_compared++; if (acc_ts !== 1) begin n_mismatched++; $display("[TB] FAIL mismatch_ts_read: got %0d, expected 1", acc_ts); end
    @(negedge clock);
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mismatch_done_pulse: got %b, expected 0", done); end
    data_id = EXP_ID;
  endtask

  task automatic test_stall;
    int cyc;
    reset_counts(); stall_cycles = 3;
    pulse_start();
    wait_done(1, cyc);
    n_compared++; if (cyc !== 11) begin n_mismatched++; $display("[TB] FAIL stall_done_cycle: got %0d, expected 11", cyc); end
    n_compared++; if (stall_broken !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_request_stable: got %b, expected 0", stall_broken); end
    n_compared++; if (acc_id !== 1 || acc_ts !== 1) begin n_mismatched++; $display("[TB] FAIL stall_accepts: got %0d/%0d, expected 1/1", acc_id, acc_ts); end
    n_compared++; if ({id_ok, ts_ok, timeout} !== 3'b110) begin n_mismatched++; $display("[TB] FAIL stall_flags: got %b, expected 110", {id_ok, ts_ok, timeout}); end
    stall_cycles = 0;
  endtask

  task automatic test_timeout;
    int cyc;
    reset_counts(); drop_ts = 1'b1;
    pulse_start();
    wait_done(1, cyc);
    n_compared++; if (cyc !== 11) begin n_mismatched++; $display("[TB] FAIL timeout_done_cycle: got %0d, expected 11", cyc); end
    n_compared++; if ({id_ok, ts_ok, timeout, avm_read} !== 4'b1010) begin n_mismatched++; $display("[TB] FAIL timeout_flags: got %b, expected 1010", {id_ok, ts_ok, timeout, avm_read}); end
    n_compared++; if (ts_value !== 32'd0) begin n_mismatched++; $display("[TB] FAIL timeout_ts_value: got %0h, expected 0", ts_value); end
    repeat (5) @(negedge clock);
    inject_data = EXP_TS; inject_rdv = 1'b1;
    repeat (3) @(negedge clock);
    n_compared++; if ({busy, ts_ok, timeout} !== 3'b001 || ts_value !== 32'd0) begin n_mismatched++; $display("[TB] FAIL timeout_late_return: got %b/%0h, expected 001/0", {busy, ts_ok, timeout}, ts_value); end
    drop_ts = 1'b0;
  endtask

  task automatic test_ignored_inputs;
    int cyc;
    reset_counts();
    pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done(3, cyc);
    n_compared++; if (cyc !== 5) begin n_mismatched++; $display("[TB] FAIL busy_start_done_cycle: got %0d, expected 5", cyc); end
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    n_compared++; if ({busy, avm_read} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL finish_start_ignored: got %b, expected 00", {busy, avm_read}); end
    repeat (4) @(negedge clock);
    n_compared++; if (busy !== 1'b0 || acc_id !== 1 || acc_ts !== 1) begin n_mismatched++; $display("[TB] FAIL no_second_run: got busy=%b acc=%0d/%0d, expected busy=0 acc=1/1", busy, acc_id, acc_ts); end
    inject_data = 32'hDEADBEEF; inject_rdv = 1'b1;
    repeat (3) @(negedge clock);
    n_compared++; if (id_value !== EXP_ID || ts_value !== EXP_TS || {id_ok, ts_ok, timeout} !== 3'b110) begin n_mismatched++; $display("[TB] FAIL stray_rdv_idle: got %0h/%0h/%b, expected %0h/%0h/110", id_value, ts_value, {id_ok, ts_ok, timeout}, EXP_ID, EXP_TS); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    reset_counts(); drop_id = 1'b1;
    pulse_start();
    repeat (2) @(negedge clock);
    n_compared++; if ({busy, avm_read} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL wait_id_before_reset: got %b, expected 10", {busy, avm_read}); end
    reset = 1'b1; #1;
    n_compared++; if ({busy, done, avm_read, id_ok, ts_ok, timeout} !== 6'b0 || id_value !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_in_wait_id: got %b/%0h, expected 000000/0", {busy, done, avm_read, id_ok, ts_ok, timeout}, id_value); end
    @(negedge clock); reset = 1'b0; drop_id = 1'b0; stall_cycles = 5;
    pulse_start();
    @(negedge clock);
    n_compared++; if ({busy, avm_read} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL req_id_before_reset: got %b, expected 11", {busy, avm_read}); end
    reset = 1'b1; #1;
    n_compared++; if ({busy, avm_read, avm_address} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_in_req_id: got %b, expected 000", {busy, avm_read, avm_address}); end
    @(negedge clock); reset = 1'b0; stall_cycles = 0;
    @(negedge clock);
    pulse_start();
    wait_done(1, cyc);
    n_compared++; if (cyc !== 5) begin n_mismatched++; $display("[TB] FAIL after_reset_done_cycle: got %0d, expected 5", cyc); end
    n_compared++; if ({id_ok, ts_ok, timeout} !== 3'b110 || ts_value !== EXP_TS) begin n_mismatched++; $display("[TB] FAIL after_reset_results: got %b/%0h, expected 110/%0h", {id_ok, ts_ok, timeout}, ts_value, EXP_TS); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_id_mismatch();
    test_stall();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sysid_read_master.md
Name: sysid_read_master

Overview:
- Avalon-MM read master that runs a boot-time identity check against the system ID peripheral.
- On a start pulse it reads word 0 (system ID), then word 1 (build timestamp), and compares each against expected parameter values.
- Reports pass/fail/timeout flags and the captured values to the control/status logic.
- Sits on the control bus beside the CPU master, so hardware can refuse mismatched software images without running a processor.

Parameters:
- EXPECTED_ID, 0, 32-bit value the slave must return at address 0.
- EXPECTED_TIMESTAMP, 1328062037, 32-bit value the slave must return at address 1.
- CHECK_TIMESTAMP, 1, 1 = read and compare word 1; 0 = finish after word 0, ts_ok forced 1.
- TIMEOUT_CYCLES, 255, max cycles per read transaction (request + data wait); legal 2..65535.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a check; ignored while busy.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the check ends (pass, fail or timeout).
- id_ok  out  1  word 0 equalled EXPECTED_ID; held until next start.
- ts_ok  out  1  word 1 equalled EXPECTED_TIMESTAMP (or CHECK_TIMESTAMP=0); held.
- timeout  out  1  a read exceeded TIMEOUT_CYCLES; held until next start.
- id_value  out  32  captured word 0; held.
- ts_value  out  32  captured word 1; held.
- avm_address  out  1  word address to slave.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; request held while high.
- avm_readdatavalid  in  1  read data strobe (pipelined, latency ≥1).
- avm_readdata  in  32  read data.

Behaviour:
- Reset values:
  - Control/handshake: busy=0, done=0, avm_read=0, avm_address=0.
  - Result flags: id_ok=0, ts_ok=0, timeout=0.
  - Captured values and counters: id_value=0, ts_value=0, timeout counter=0.
  - State: IDLE.
- State machine:
  - IDLE:
    - On start=1, clear id_ok/ts_ok/timeout/id_value/ts_value and the counter.
    - Go to REQ_ID; busy=1 from the next cycle.
  - REQ_ID: avm_read=1, avm_address=0.
    - Accepted on a cycle with avm_read & !avm_waitrequest; then go to WAIT_ID and drop avm_read.
  - WAIT_ID: avm_read=0.
    - On avm_readdatavalid, capture id_value, set id_ok = (readdata==EXPECTED_ID).
    - Then go to REQ_TS if CHECK_TIMESTAMP, else FINISH with ts_ok=1.
  - REQ_TS / WAIT_TS: same as REQ_ID / WAIT_ID with avm_address=1, capturing into ts_value/ts_ok.
  - FINISH:
    - done=1 for exactly one cycle, busy=0 in that same cycle.
    - Return to IDLE.
- Minimum latency, zero-wait slave with 1-cycle readdatavalid:
  - start at cycle 0 → REQ_ID at 1, WAIT_ID at 2, data at 2 → REQ_TS at 3, WAIT_TS at 4, data at 4 → done at 5.
- Timeout:
  - Counter clears on entry to each REQ state and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without the relevant event: deassert avm_read, set timeout=1, go to FINISH.
  - Flags for the unfinished read and any later read stay 0.
- Stray strobes: avm_readdatavalid outside WAIT_ID/WAIT_TS is ignored, including a late return after a timeout.
- Simultaneous events:
  - readdatavalid on the same cycle as timeout expiry: data wins (capture, no timeout).
  - start in the FINISH cycle: ignored.
- Reset mid-transaction: immediate return to reset values; avm_read drops asynchronously. No completion is owed to the slave, since reads are side-effect free.
- avm_address and avm_read are registered outputs and stable while waitrequest is high.
- Comparisons are full 32-bit unsigned equality.

Decomposition:
- Shared package holds:
  - state enum: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH;
  - address constants ADDR_ID=0, ADDR_TS=1;
  - counter width localparam derived as clog2(TIMEOUT_CYCLES).
- One natural sub-module: sysid_read_timer (loadable saturating down/up counter with expire flag), reused per transaction.
- The rest stays flat.

Test Plan:
- Zero-wait slave returning 0 then 1328062037, latency 1 → done at cycle 5 after start; id_ok=1, ts_ok=1, timeout=0; id_value=0, ts_value=1328062037.
- Slave returns 0x12345678 at address 0 → id_ok=0; id_value=0x12345678; ts still read; done asserted once.
- avm_waitrequest held high 3 cycles on each read → avm_read and avm_address stable through the stall; exactly one accepted read per address; results correct.
- TIMEOUT_CYCLES=8, slave never asserts readdatavalid for address 1 → timeout=1, id_ok=1, ts_ok=0, done 8 cycles after address-1 request entry; a late readdatavalid 5 cycles later changes nothing.
- start pulsed while busy, and a stray readdatavalid in IDLE → no second run, no flag change.
- reset asserted while in WAIT_ID → avm_read=0, busy=0, all flags 0 immediately; a fresh start after release completes normally.
